// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//
// Constants shared by the program-counter sequencer and the control unit.
//
// Contents:
//   pc_src_e          next-PC select encoding driven on PCSrc
//   DEFAULT_STEP      byte increment of one sequential instruction
//   DEFAULT_RESET_PC  address fetched after reset
//   JUMP_FIELD_W      width of the J-format target field
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Next-PC source select. The control unit decodes the opcode into one of
    // these and the sequencer multiplexes on it.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_src_e;

    localparam int unsigned DEFAULT_STEP     = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned JUMP_FIELD_W     = 26;

endpackage : cpu_pkg

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
//
// Small circular return-address stack. Subroutine calls push their link
// address; returns pop it so the sequencer can predict the return target.
// When the stack is already full a push overwrites the oldest entry.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; empties the stack
//   push   in   store din as the new top entry
//   pop    in   discard the top entry (ignored while empty)
//   din    in   WIDTH  address to push
//   top    out  WIDTH  current top entry (meaningless while empty)
//   empty  out  no entries held
//   full   out  RAS_DEPTH entries held
//
// push and a valid pop in the same cycle replace the top entry in place,
// leaving the pointer and the occupancy count unchanged.
// ---------------------------------------------------------------------------
module return_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0] tp;
    logic [PTR_W-1:0] tp_inc;
    logic [PTR_W-1:0] tp_dec;
    logic [CNT_W-1:0] count;

    logic valid_pop;
    logic replace;
    logic plain_push;
    logic plain_pop;

    // Depth is a power of two, so the pointer wraps naturally in PTR_W bits.
    assign tp_inc = tp + PTR_W'(1);
    assign tp_dec = tp - PTR_W'(1);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(RAS_DEPTH));

    // A pop against an empty stack is dropped, which turns call+pop-on-empty
    // into an ordinary push.
    assign valid_pop  = pop & ~empty;
    assign replace    = push & valid_pop;
    assign plain_push = push & ~valid_pop;
    assign plain_pop  = valid_pop & ~push;

    assign top = entries[tp];

    // Pointer and occupancy. On overflow the pointer still advances so the
    // newest entry overwrites the oldest one, but the count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            tp    <= '0;
            count <= '0;
        end else if (plain_push) begin
            tp <= tp_inc;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (plain_pop) begin
            tp    <= tp_dec;
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage has no reset; entries above the count are never read.
    // Writes are blocked during reset so a reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (replace) begin
                entries[tp] <= din;
            end else if (plain_push) begin
                entries[tp_inc] <= din;
            end
        end
    end

endmodule : return_stack

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Registered program counter for the single-cycle CPU. Selects the next PC
// from the sequential, branch, jump or register/return sources and keeps a
// return-address stack to predict subroutine returns.
//
// Parameters:
//   WIDTH      PC/address width (>= 32)
//   RESET_PC   PC loaded on reset
//   STEP       byte increment per sequential instruction
//   RAS_DEPTH  return-stack entries, power of two >= 2
//
// Ports:
//   CLK         in   rising-edge clock
//   Reset       in   synchronous active-high reset
//   PCWre       in   PC write enable, 0 stalls PC and stack
//   PCSrc       in   2      next-PC select (cpu_pkg::pc_src_e)
//   immediate   in   WIDTH  sign-extended branch offset in words
//   jumpTarget  in   26     J-format target field
//   regTarget   in   WIDTH  rs value for jr/jalr
//   call        in   instruction links; push pcPlus
//   ret         in   instruction is jr $ra; predict from the stack
//   curPC       out  WIDTH  registered current PC
//   pcPlus      out  WIDTH  curPC + STEP, combinational
//   rasEmpty    out  stack holds no entries
//   rasFull     out  stack holds RAS_DEPTH entries
// ---------------------------------------------------------------------------
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      STEP      = DEFAULT_STEP,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    PCWre,
    input  logic [1:0]              PCSrc,
    input  logic [WIDTH-1:0]        immediate,
    input  logic [JUMP_FIELD_W-1:0] jumpTarget,
    input  logic [WIDTH-1:0]        regTarget,
    input  logic                    call,
    input  logic                    ret,
    output logic [WIDTH-1:0]        curPC,
    output logic [WIDTH-1:0]        pcPlus,
    output logic                    rasEmpty,
    output logic                    rasFull
);

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] reg_target;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;
    logic             is_reg_src;

    assign pcPlus = curPC + WIDTH'(STEP);

    // Offsets are in words; the shift drops the top two bits, which is the
    // intended modulo-2^WIDTH behaviour.
    assign branch_target = pcPlus + (immediate << 2);

    // Region bits come from the incremented PC, as on MIPS.
    assign jump_target = {pcPlus[WIDTH-1:28], jumpTarget, 2'b00};

    assign is_reg_src = (pc_src_e'(PCSrc) == PC_REG);

    // A predicted return only applies when the stack has something to give;
    // otherwise the architectural rs value is used.
    assign reg_target = (ret && !rasEmpty) ? ras_top : regTarget;

    // Stalls freeze the stack along with the PC, so call/ret are gated here.
    assign ras_push = PCWre & call;
    assign ras_pop  = PCWre & ret & is_reg_src;

    // Next-PC multiplexer.
    always_comb begin
        next_pc = pcPlus;
        case (pc_src_e'(PCSrc))
            PC_SEQ:    next_pc = pcPlus;
            PC_BRANCH: next_pc = branch_target;
            PC_JUMP:   next_pc = jump_target;
            PC_REG:    next_pc = reg_target;
            default:   next_pc = pcPlus;
        endcase
    end

    // PC register; reset dominates the write enable.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            curPC <= RESET_PC;
        end else if (PCWre) begin
            curPC <= next_pc;
        end
    end

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clk   (CLK),
        .reset (Reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pcPlus),
        .top   (ras_top),
        .empty (rasEmpty),
        .full  (rasFull)
    );

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Each step drives one cycle of control
// inputs and queues the PC and stack flags expected after the next rising
// edge; the queued entry is then popped and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] immediate;
    logic [25:0] jumpTarget;
    logic [31:0] regTarget;
    logic        call;
    logic        ret;
    logic [31:0] curPC;
    logic [31:0] pcPlus;
    logic        rasEmpty;
    logic        rasFull;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   compare_count  = 0;
    int   mismatch_count = 0;

    pc_sequencer #(
        .WIDTH     (32),
        .RESET_PC  (32'h0000_0000),
        .STEP      (4),
        .RAS_DEPTH (4)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .immediate  (immediate),
        .jumpTarget (jumpTarget),
        .regTarget  (regTarget),
        .call       (call),
        .ret        (ret),
        .curPC      (curPC),
        .pcPlus     (pcPlus),
        .rasEmpty   (rasEmpty),
        .rasFull    (rasFull)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One comparison point.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Pop the oldest expectation and compare the DUT against it.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compare_count++;
            mismatch_count++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        checkValue({e.tag, ".curPC"},    curPC,            e.pc);
        checkValue({e.tag, ".pcPlus"},   pcPlus,           e.pc + 32'd4);
        checkValue({e.tag, ".rasEmpty"}, {31'd0, rasEmpty}, {31'd0, e.empty});
        checkValue({e.tag, ".rasFull"},  {31'd0, rasFull},  {31'd0, e.full});
    endtask

    // Drive one cycle of inputs, queue the expected result, clock, compare.
    task automatic applyStimulus(input string tag, input logic rst, input logic we,
                                 input logic [1:0] src, input logic [31:0] imm,
                                 input logic [25:0] jt, input logic [31:0] rt,
                                 input logic c, input logic r,
                                 input logic [31:0] exp_pc, input logic exp_empty,
                                 input logic exp_full);
        exp_t e;
        Reset      = rst;
        PCWre      = we;
        PCSrc      = src;
        immediate  = imm;
        jumpTarget = jt;
        regTarget  = rt;
        call       = c;
        ret        = r;
        e.tag   = tag;
        e.pc    = exp_pc;
        e.empty = exp_empty;
        e.full  = exp_full;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; immediate = '0;
        jumpTarget = '0; regTarget = '0; call = 1'b0; ret = 1'b0;
        $display("[TB] start");

        //            tag        rst we src    imm           jt       rt            c  r  pc            E  F
        applyStimulus("reset",   1, 0, 2'b00, 32'h0,        26'h0,   32'h0,        0, 0, 32'h0000_0000, 1, 0);
        applyStimulus("seq1",    0, 1, 2'b00, 32'h0,        26'h0,   32'h0,        0, 0, 32'h0000_0004, 1, 0);
        applyStimulus("seq2",    0, 1, 2'b00, 32'h0,        26'h0,   32'h0,        0, 0, 32'h0000_0008, 1, 0);
        applyStimulus("seq3",    0, 1, 2'b00, 32'h0,        26'h0,   32'h0,        0, 0, 32'h0000_000C, 1, 0);
        applyStimulus("go100",   0, 1, 2'b11, 32'h0,        26'h0,   32'h100,      0, 0, 32'h0000_0100, 1, 0);
        applyStimulus("branch",  0, 1, 2'b01, 32'hFFFF_FFFE, 26'h0,  32'h0,        0, 0, 32'h0000_00FC, 1, 0);
        applyStimulus("goF000",  0, 1, 2'b11, 32'h0,        26'h0,   32'hF000_0000, 0, 0, 32'hF000_0000, 1, 0);
        applyStimulus("jump",    0, 1, 2'b10, 32'h0,        26'h40,  32'h0,        0, 0, 32'hF000_0100, 1, 0);
        applyStimulus("stall1",  0, 0, 2'b00, 32'h0,        26'h0,   32'h0,        1, 0, 32'hF000_0100, 1, 0);
        applyStimulus("stall2",  0, 0, 2'b00, 32'h0,        26'h0,   32'h0,        1, 0, 32'hF000_0100, 1, 0);
        applyStimulus("goTop",   0, 1, 2'b11, 32'h0,        26'h0,   32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0);
        applyStimulus("wrap",    0, 1, 2'b00, 32'h0,        26'h0,   32'h0,        0, 0, 32'h0000_0000, 1, 0);
        applyStimulus("go10",    0, 1, 2'b11, 32'h0,        26'h0,   32'h10,       0, 0, 32'h0000_0010, 1, 0);
        applyStimulus("call1",   0, 1, 2'b11, 32'h0,        26'h0,   32'h20,       1, 0, 32'h0000_0020, 0, 0);
        applyStimulus("call2",   0, 1, 2'b11, 32'h0,        26'h0,   32'h30,       1, 0, 32'h0000_0030, 0, 0);
        applyStimulus("call3",   0, 1, 2'b11, 32'h0,        26'h0,   32'h40,       1, 0, 32'h0000_0040, 0, 0);
        applyStimulus("call4",   0, 1, 2'b11, 32'h0,        26'h0,   32'h50,       1, 0, 32'h0000_0050, 0, 1);
        applyStimulus("call5",   0, 1, 2'b11, 32'h0,        26'h0,   32'h60,       1, 0, 32'h0000_0060, 0, 1);
        applyStimulus("ret1",    0, 1, 2'b11, 32'h0,        26'h0,   32'hDEAD_0000, 0, 1, 32'h0000_0054, 0, 0);
        applyStimulus("ret2",    0, 1, 2'b11, 32'h0,        26'h0,   32'hDEAD_0000, 0, 1, 32'h0000_0044, 0, 0);
        applyStimulus("ret3",    0, 1, 2'b11, 32'h0,        26'h0,   32'hDEAD_0000, 0, 1, 32'h0000_0034, 0, 0);
        applyStimulus("ret4",    0, 1, 2'b11, 32'h0,        26'h0,   32'hDEAD_0000, 0, 1, 32'h0000_0024, 1, 0);
        applyStimulus("ret5",    0, 1, 2'b11, 32'h0,        26'h0,   32'h900,      0, 1, 32'h0000_0900, 1, 0);
        applyStimulus("go80",    0, 1, 2'b11, 32'h0,        26'h0,   32'h80,       0, 0, 32'h0000_0080, 1, 0);
        applyStimulus("call84",  0, 1, 2'b11, 32'h0,        26'h0,   32'h200,      1, 0, 32'h0000_0200, 0, 0);
        applyStimulus("callret", 0, 1, 2'b11, 32'h0,        26'h0,   32'hBAD0,     1, 1, 32'h0000_0084, 0, 0);
        applyStimulus("retRepl", 0, 1, 2'b11, 32'h0,        26'h0,   32'hBAD0,     0, 1, 32'h0000_0204, 1, 0);
        applyStimulus("push1",   0, 1, 2'b11, 32'h0,        26'h0,   32'h500,      1, 0, 32'h0000_0500, 0, 0);
        applyStimulus("push2",   0, 1, 2'b11, 32'h0,        26'h0,   32'h600,      1, 0, 32'h0000_0600, 0, 0);
        applyStimulus("retSeq",  0, 1, 2'b00, 32'h0,        26'h0,   32'hBAD0,     0, 1, 32'h0000_0604, 0, 0);
        applyStimulus("retStal", 0, 0, 2'b11, 32'h0,        26'h0,   32'hBAD0,     0, 1, 32'h0000_0604, 0, 0);
        applyStimulus("midRst",  1, 1, 2'b11, 32'h0,        26'h0,   32'hBAD0,     1, 1, 32'h0000_0000, 1, 0);
        applyStimulus("retPost", 0, 1, 2'b11, 32'h0,        26'h0,   32'h300,      0, 1, 32'h0000_0300, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle CPU. It replaces the free-running "PC plus 4" adder with a registered PC that holds its value during a stall and selects among four next-PC sources: sequential, branch, jump and register. A small circular return-address stack (RAS) supplies targets for subroutine returns. It sits between the control unit and instruction memory: `curPC` drives the instruction-memory address, and `pcPlus` feeds the link-register write path.

## Interface
- `WIDTH`, 32, PC/address width; must be ≥ 32.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `STEP`, 4, byte increment per sequential instruction.
- `RAS_DEPTH`, 4, number of RAS entries; a power of two ≥ 2.
- `CLK`  input  1  rising-edge clock; the only clock.
- `Reset`  input  1  synchronous, active-high reset.
- `PCWre`  input  1  PC write enable; 0 = stall.
- `PCSrc`  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 register/return.
- `immediate`  input  WIDTH  sign-extended branch offset, in words.
- `jumpTarget`  input  26  J-format target field.
- `regTarget`  input  WIDTH  rs value for jr/jalr.
- `call`  input  1  current instruction links (jal/jalr); push `pcPlus` onto the RAS.
- `ret`  input  1  current instruction is `jr $ra`; take the target from the RAS.
- `curPC`  output  WIDTH  registered current PC.
- `pcPlus`  output  WIDTH  combinational `curPC + STEP`.
- `rasEmpty`  output  1  RAS holds no entries.
- `rasFull`  output  1  RAS holds `RAS_DEPTH` entries.

## Operation
- All arithmetic is modulo 2^WIDTH; carries out are discarded.
- Sequential next PC: `curPC + STEP`.
- Branch target: `pcPlus + (immediate << 2)`.
- Jump target: {`pcPlus[WIDTH-1:28]`, `jumpTarget`, 2'b00}.
- Register target (`PCSrc`=11):
  - `ret`=1 and RAS not empty: use the RAS top entry.
  - Otherwise: use `regTarget`.
- `ret` is ignored when `PCSrc`≠11. `call` is honoured for any `PCSrc`.
- RAS state: `RAS_DEPTH` × WIDTH entries, top pointer `tp`, `count` in 0..`RAS_DEPTH`.
- Push (`call`): write `pcPlus` at `tp+1`, advance `tp`, then:
  - if `count` < `RAS_DEPTH`, increment `count`;
  - if `count` = `RAS_DEPTH` (full), leave `count` unchanged; the oldest entry is overwritten (wrap-around).
- Pop (`ret` with `PCSrc`=11, not empty): retreat `tp`, decrement `count`.
- Pop on empty: no RAS change; `regTarget` is used.
- `call` and valid pop together (jalr to `$ra`):
  - next PC = old top entry;
  - top entry is replaced by `pcPlus`;
  - `tp` and `count` unchanged.
- `call` and pop-on-empty together: behaves as a plain push.
- `PCWre`=0: `curPC`, RAS contents, `tp` and `count` all hold; `call`/`ret` are ignored.
- Misaligned targets (low 2 bits ≠ 0) are passed through unmodified; no exception is raised.

## Timing
- On the rising edge with `Reset`=1:
  - `curPC` ← `RESET_PC`;
  - `tp` ← 0, `count` ← 0, so `rasEmpty`=1 and `rasFull`=0;
  - RAS data contents are don't-care.
- `Reset` overrides `PCWre`, `call` and `ret`; a reset issued mid-sequence discards all stacked returns.
- Update latency is one cycle: next-PC selection is combinational from the current inputs and is registered on the next rising edge when `PCWre`=1.
- `pcPlus` is combinational from `curPC` with zero-cycle latency. `rasEmpty`/`rasFull` are decoded from registered `count`.
- The RAS top entry is read combinationally from registered state, so a push followed by a pop in the next cycle returns the pushed value (no bypass is needed).
- No X may propagate to `curPC` after the first reset edge.

## Structure
- Shared package `cpu_pkg`: `PCSrc` encoding constants (`PC_SEQ`, `PC_BRANCH`, `PC_JUMP`, `PC_REG`) and the default `STEP`/`RESET_PC` values; the control unit uses the same constants.
- One sub-module, `return_stack`, parametrised by `WIDTH` and `RAS_DEPTH`:
  - inputs: `push`, `pop`, `din`;
  - outputs: `top`, `empty`, `full`;
  - implements the push/pop/replace/overflow rules above.
- The top level holds the PC register, the adders and the next-PC multiplexer.

## Test plan
- Reset, then `PCWre`=1, `PCSrc`=00 for 3 cycles → `curPC` = 0, 4, 8, 12; `rasEmpty`=1 throughout.
- At `curPC`=0x100: `PCSrc`=01, `immediate`=−2 → next `curPC`=0xFC. Then `PCSrc`=10, `jumpTarget`=0x40, at `curPC`=0xF000_0000 → next `curPC`=0xF000_0100.
- Stall: `PCWre`=0 for 2 cycles with `call`=1 → `curPC` and `count` unchanged. Wrap-around: `curPC`=0xFFFF_FFFC, `PCSrc`=00 → 0x0000_0000.
- Five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 (`RAS_DEPTH`=4) → `rasFull`=1 after the fourth call. Four returns then give 0x54, 0x44, 0x34, 0x24. A fifth return with `regTarget`=0x900 → `curPC`=0x900, `rasEmpty`=1.
- Simultaneous `call`+`ret` at `curPC`=0x200 with top entry 0x84 → next `curPC`=0x84, new top entry=0x204, `count` unchanged.
- After two pushes, assert `Reset` → `curPC`=`RESET_PC`, `rasEmpty`=1. A subsequent `ret` with `regTarget`=0x300 → `curPC`=0x300.
